// File: rtl/chip_bus_pkg.sv
// Shared types and constants for the chip-RAM CAS sequencer.
package chip_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DMA  = 2'd3
  } state_e;

  // Default ROM decode: {A20,A19} == 00 or 11 selects ROM.
  localparam logic [3:0] ROM_MAP_DEF = 4'b1001;

  // Width of the CAS hold counter; CAS_HOLD is limited to 1..15.
  localparam int HOLD_W = 4;

endpackage

// File: rtl/cas_hold_timer.sv
// Loadable, saturating down-counter that times the minimum CAS assertion.
module cas_hold_timer
  import chip_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [HOLD_W-1:0] load_val,
  output logic              zero
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/chip_cas_sequencer.sv
// Sequences CPU read/write and DMA cycles onto chip-RAM byte lanes.
module chip_cas_sequencer
  import chip_bus_pkg::*;
#(
  parameter int         LANES    = 2,
  parameter logic [3:0] ROM_MAP  = ROM_MAP_DEF,
  parameter int         CAS_HOLD = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             C1,
  input  logic             PRW,
  input  logic [LANES-1:0] DS,
  input  logic [1:0]       A,
  input  logic             ROME,
  input  logic             RE,
  input  logic             RGAE,
  input  logic             DAE,
  input  logic             ARW,
  output logic             ROM_SEL,
  output logic [LANES-1:0] CEN,
  output logic             CDR,
  output logic             CDW,
  output logic             RRW,
  output logic             BUSY
);

  // The entry clock already registers the first CAS cycle, so the counter
  // only has to cover the remaining CAS_HOLD-1 cycles.
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CAS_HOLD - 1);

  state_e           state_q, state_d;
  logic             c1_q, c1_d;
  logic             rom_q, rom_d;
  logic [LANES-1:0] cen_q, cen_d;
  logic             cdr_q, cdr_d;
  logic             cdw_q, cdw_d;
  logic             rrw_q, rrw_d;
  logic             busy_q, busy_d;

  logic             hold_load, hold_dec, hold_zero;
  logic             c1_rise, ds_idle, cpu_req, cen_hold;
  logic [LANES-1:0] lane_cen;

  assign c1_rise  = C1 & ~c1_q;
  assign ds_idle  = (DS == '0);
  assign cpu_req  = RE | RGAE;
  assign lane_cen = DS & {LANES{RE}};
  // Keep the previous lane pattern while strobes are gone but hold time remains.
  assign cen_hold = ds_idle && !hold_zero && (state_q == state_d);

  cas_hold_timer u_hold (
    .clk      (CLK),
    .rst      (RST),
    .load     (hold_load),
    .dec      (hold_dec),
    .load_val (HOLD_INIT),
    .zero     (hold_zero)
  );

  // Next-state logic; a pending DMA request takes the bus straight after a CPU cycle.
  always_comb begin
    state_d   = state_q;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (DAE) begin
          state_d = DMA;
        end else if (cpu_req && !PRW && !C1) begin
          state_d   = RD;
          hold_load = 1'b1;
        end else if (cpu_req && PRW) begin
          state_d   = WR;
          hold_load = 1'b1;
        end
      end
      RD: begin
        hold_dec = 1'b1;
        if (ds_idle && hold_zero) state_d = DAE ? DMA : IDLE;
      end
      WR: begin
        hold_dec = 1'b1;
        if (ds_idle && hold_zero && C1) state_d = DAE ? DMA : IDLE;
      end
      DMA: begin
        if (!DAE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so outputs register together with it.
  always_comb begin
    c1_d   = C1;
    rom_d  = ROME & ~PRW & ROM_MAP[A];
    cen_d  = '0;
    cdr_d  = 1'b0;
    cdw_d  = 1'b0;
    rrw_d  = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      RD: begin
        cdr_d = 1'b1;
        cen_d = cen_hold ? cen_q : lane_cen;
      end
      WR: begin
        cdw_d = 1'b1;
        rrw_d = RE;
        cen_d = cen_hold ? cen_q : lane_cen;
      end
      DMA: begin
        cen_d = '1;
        if (c1_rise)               rrw_d = ARW;
        else if (state_q == DMA)   rrw_d = rrw_q;
      end
      default: ;
    endcase
  end

  // State and output registers; reset clears everything, even mid-cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      c1_q    <= 1'b0;
      rom_q   <= 1'b0;
      cen_q   <= '0;
      cdr_q   <= 1'b0;
      cdw_q   <= 1'b0;
      rrw_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      rom_q   <= rom_d;
      cen_q   <= cen_d;
      cdr_q   <= cdr_d;
      cdw_q   <= cdw_d;
      rrw_q   <= rrw_d;
      busy_q  <= busy_d;
    end
  end

  assign ROM_SEL = rom_q;
  assign CEN     = cen_q;
  assign CDR     = cdr_q;
  assign CDW     = cdw_q;
  assign RRW     = rrw_q;
  assign BUSY    = busy_q;

endmodule
